rf_read_arbiter: RTL and testbench

//  Shares the integer regfile's NUM_RDPORT physical read ports among NUM_REQ issue-queue issue ports.

---
 rtl/rf_read_arbiter.sv | 138 +++++++++++++
 tb/tb_rf_read_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: shares the integer regfile read ports among the issue ports.
// Whole requests are granted or denied in one cycle. Walk order is starving
// requesters first, then round-robin from rr_ptr. Issue-queue feedback
// (finished / replay) follows one cycle after the request.
module rf_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_RDPORT   = 6,
  parameter int NUMSRCS      = 2,
  parameter int IQ_DEPTH     = 8,
  parameter int STARVE_LIMIT = 3,
  parameter int IPR_W        = 7,
  localparam int IDXW  = $clog2(IQ_DEPTH),
  localparam int PORTW = $clog2(NUM_RDPORT),
  localparam int CNTW  = $clog2(STARVE_LIMIT + 1),
  localparam int RRW   = $clog2(NUM_REQ)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_stall,
  input  logic [NUM_REQ-1:0]                            i_req_vld,
  input  logic [NUM_REQ-1:0][IDXW-1:0]                  i_req_idx,
  input  logic [NUM_REQ-1:0][NUMSRCS-1:0]               i_req_src_need,
  input  logic [NUM_REQ-1:0][NUMSRCS-1:0][IPR_W-1:0]    i_req_src_idx,
  output logic [NUM_REQ-1:0]                            o_grant,
  output logic [NUM_REQ-1:0][NUMSRCS-1:0][PORTW-1:0]    o_src_port,
  output logic [NUM_RDPORT-1:0]                         o_rf_rd_vld,
  output logic [NUM_RDPORT-1:0][IPR_W-1:0]              o_rf_rd_idx,
  output logic [NUM_REQ-1:0]                            o_fb_finished,
  output logic [NUM_REQ-1:0]                            o_fb_replay,
  output logic [NUM_REQ-1:0][IDXW-1:0]                  o_fb_idx
);

  logic [RRW-1:0]                rr_ptr;
  logic [NUM_REQ-1:0][CNTW-1:0]  starve_cnt;
  logic [NUM_REQ-1:0]            starving;
  logic [RRW-1:0]                cur;
  logic [PORTW-1:0]              port;
  logic                          pick;
  int                            used;
  int                            need;
  int                            slot;

  // A requester is starving when it is valid and has hit the replay limit.
  always_comb begin
    starving = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      starving[r] = i_req_vld[r] && (starve_cnt[r] == CNTW'(STARVE_LIMIT));
    end
  end

  // Grant walk: pass 0 visits starving requesters by index, pass 1 the rest in rr order.
  always_comb begin
    o_grant     = '0;
    o_src_port  = '0;
    o_rf_rd_vld = '0;
    o_rf_rd_idx = '0;
    used        = 0;
    need        = 0;
    slot        = 0;
    cur         = '0;
    port        = '0;
    pick        = 1'b0;
    if (!rst && !i_stall) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (pass == 0) begin
            slot = k;
          end else begin
            slot = int'(rr_ptr) + k;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
          end
          cur  = RRW'(slot);
          pick = (pass == 0) ? starving[cur] : !starving[cur];
          need = 0;
          for (int s = 0; s < NUMSRCS; s++) begin
            need = need + int'(i_req_src_need[cur][s]);
          end
          if (pick && i_req_vld[cur] && (used + need <= NUM_RDPORT)) begin
            o_grant[cur] = 1'b1;
            for (int s = 0; s < NUMSRCS; s++) begin
              if (i_req_src_need[cur][s]) begin
                port                   = PORTW'(used);
                o_src_port[cur][s]     = port;
                o_rf_rd_vld[port]      = 1'b1;
                o_rf_rd_idx[port]      = i_req_src_idx[cur][s];
                used                   = used + 1;
              end
            end
          end
        end
      end
    end
  end

  // Feedback register: grant/deny result one cycle later, zeroed on stall and reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_fb_finished <= '0;
      o_fb_replay   <= '0;
      o_fb_idx      <= '0;
    end else if (i_stall) begin
      o_fb_finished <= '0;
      o_fb_replay   <= '0;
    end else begin
      o_fb_finished <= o_grant;
      o_fb_replay   <= i_req_vld & ~o_grant;
      o_fb_idx      <= i_req_idx;
    end
  end

  // Round-robin pointer advances on every non-stalled cycle that saw a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (!i_stall && (|i_req_vld)) begin
      rr_ptr <= (rr_ptr == RRW'(NUM_REQ - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  // Starve counters count consecutive replays and clear on grant or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_stall) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (i_req_vld[r] && !o_grant[r]) begin
          if (starve_cnt[r] != CNTW'(STARVE_LIMIT)) starve_cnt[r] <= starve_cnt[r] + 1'b1;
        end else begin
          starve_cnt[r] <= '0;
        end
      end
    end
  end

  // An entry can never be both finished and replayed.
  fb_exclusive: assert property (@(posedge clk) disable iff (rst) (o_fb_finished & o_fb_replay) == '0);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// tb_rf_read_arbiter: directed table plus random traffic against two instances,
// the default 6-port build and a 3-port build with a starve limit of 1, both
// compared against a reference model and a feedback scoreboard.
module tb_rf_read_arbiter;

  typedef logic [3:0][1:0][6:0] sidx_t;
  typedef logic [3:0][1:0][2:0] sport_t;
  typedef logic [5:0][6:0]      rdidx_t;

  typedef struct packed {
    logic [3:0]      fin;
    logic [3:0]      rep;
    logic [3:0][2:0] idx;
  } fb_t;

  typedef struct packed {
    logic       r;
    logic       st;
    logic [3:0] v;
    logic [7:0] nd;
    logic [3:0] eg;
    logic [5:0] erv;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic [3:0]      vld;
  logic [3:0][2:0] idx;
  logic [3:0][1:0] need;
  sidx_t           sidx;

  logic [3:0]            grant_a, fin_a, rep_a;
  logic [3:0][1:0][2:0]  sport_a;
  logic [5:0]            rvld_a;
  logic [5:0][6:0]       ridx_a;
  logic [3:0][2:0]       fidx_a;

  logic [3:0]            grant_b, fin_b, rep_b;
  logic [3:0][1:0][1:0]  sport_b;
  logic [2:0]            rvld_b;
  logic [2:0][6:0]       ridx_b;
  logic [3:0][2:0]       fidx_b;

  int compared   = 0;
  int mismatched = 0;

  int              rr_a, rr_b;
  logic [3:0][1:0] cnt_a, cnt_b;
  logic [3:0][2:0] held_a, held_b;
  fb_t             sb_a[$];
  fb_t             sb_b[$];
  vec_t            tbl[14];

  always #5 clk = ~clk;

  rf_read_arbiter dut_a (
    .clk(clk), .rst(rst), .i_stall(stall), .i_req_vld(vld), .i_req_idx(idx),
    .i_req_src_need(need), .i_req_src_idx(sidx), .o_grant(grant_a), .o_src_port(sport_a),
    .o_rf_rd_vld(rvld_a), .o_rf_rd_idx(ridx_a), .o_fb_finished(fin_a), .o_fb_replay(rep_a),
    .o_fb_idx(fidx_a)
  );

  rf_read_arbiter #(.NUM_RDPORT(3), .STARVE_LIMIT(1)) dut_b (
    .clk(clk), .rst(rst), .i_stall(stall), .i_req_vld(vld), .i_req_idx(idx),
    .i_req_src_need(need), .i_req_src_idx(sidx), .o_grant(grant_b), .o_src_port(sport_b),
    .o_rf_rd_vld(rvld_b), .o_rf_rd_idx(ridx_b), .o_fb_finished(fin_b), .o_fb_replay(rep_b),
    .o_fb_idx(fidx_b)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arbiter: builds the explicit visit order, then fills ports in order.
  function automatic void arbModel(input int nports, input int limit, input int rr,
                                   input logic [3:0][1:0] cnt, output logic [3:0] g,
                                   output sport_t sp, output logic [5:0] rv, output rdidx_t ri);
    int order[$];
    int used;
    int n;
    int r;
    g = '0; sp = '0; rv = '0; ri = '0; used = 0;
    if (rst || stall) return;
    for (int q = 0; q < 4; q++)
      if (vld[q] && int'(cnt[q]) == limit) order.push_back(q);
    for (int k = 0; k < 4; k++) begin
      r = (rr + k) % 4;
      if (!(vld[r] && int'(cnt[r]) == limit)) order.push_back(r);
    end
    foreach (order[i]) begin
      r = order[i];
      n = int'(need[r][0]) + int'(need[r][1]);
      if (vld[r] && used + n <= nports) begin
        g[r] = 1'b1;
        for (int s = 0; s < 2; s++) begin
          if (need[r][s]) begin
            sp[r][s] = 3'(used);
            rv[used] = 1'b1;
            ri[used] = sidx[r][s];
            used++;
          end
        end
      end
    end
  endfunction

  task automatic advanceModel(input int limit, input logic [3:0] g, inout int rr,
                              inout logic [3:0][1:0] cnt, inout logic [3:0][2:0] held,
                              output fb_t e);
    e = '0;
    if (rst) begin
      rr = 0; cnt = '0; held = '0;
    end else if (stall) begin
      e.idx = held;
    end else begin
      e.fin = g;
      e.rep = vld & ~g;
      e.idx = idx;
      held  = idx;
      for (int r = 0; r < 4; r++) begin
        if (vld[r] && !g[r]) begin
          if (int'(cnt[r]) < limit) cnt[r] = cnt[r] + 2'd1;
        end else begin
          cnt[r] = 2'd0;
        end
      end
      if (|vld) rr = (rr + 1) % 4;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic [3:0] v, input logic [7:0] nd);
    rst   = r;
    stall = st;
    vld   = v;
    need  = nd;
    idx   = 12'($urandom());
    sidx  = 56'({$urandom(), $urandom()});
  endtask

  // One cycle: compare combinational outputs and feedback at negedge, then advance.
  task automatic runCycle(input string tag, input logic chk_a, input logic [3:0] eg,
                          input logic [5:0] erv, input logic chk_b, input logic [3:0] egb);
    logic [3:0]  g;
    sport_t      sp;
    logic [5:0]  rv;
    rdidx_t      ri;
    fb_t         e;
    logic [15:0] spb;
    @(negedge clk);
    arbModel(6, 3, rr_a, cnt_a, g, sp, rv, ri);
    if (chk_a) begin
      checkOutput({tag, ".a.tbl_grant"}, 64'(grant_a), 64'(eg));
      checkOutput({tag, ".a.tbl_rd_vld"}, 64'(rvld_a), 64'(erv));
    end
    checkOutput({tag, ".a.grant"}, 64'(grant_a), 64'(g));
    checkOutput({tag, ".a.src_port"}, 64'(sport_a), 64'(sp));
    checkOutput({tag, ".a.rd_vld"}, 64'(rvld_a), 64'(rv));
    checkOutput({tag, ".a.rd_idx"}, 64'(ridx_a), 64'(ri));
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < 2; s++)
        if (grant_a[r] && need[r][s])
          checkOutput({tag, ".a.port_lookup"}, 64'(ridx_a[sport_a[r][s]]), 64'(sidx[r][s]));
    e = sb_a.pop_front();
    checkOutput({tag, ".a.fb_finished"}, 64'(fin_a), 64'(e.fin));
    checkOutput({tag, ".a.fb_replay"}, 64'(rep_a), 64'(e.rep));
    checkOutput({tag, ".a.fb_idx"}, 64'(fidx_a), 64'(e.idx));
    advanceModel(3, g, rr_a, cnt_a, held_a, e);
    sb_a.push_back(e);

    arbModel(3, 1, rr_b, cnt_b, g, sp, rv, ri);
    if (chk_b) checkOutput({tag, ".b.tbl_grant"}, 64'(grant_b), 64'(egb));
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < 2; s++)
        spb[(r*2+s)*2 +: 2] = sp[r][s][1:0];
    checkOutput({tag, ".b.grant"}, 64'(grant_b), 64'(g));
    checkOutput({tag, ".b.src_port"}, 64'(sport_b), 64'(spb));
    checkOutput({tag, ".b.rd_vld"}, 64'(rvld_b), 64'(rv[2:0]));
    checkOutput({tag, ".b.rd_idx"}, 64'(ridx_b), 64'(ri[2:0]));
    e = sb_b.pop_front();
    checkOutput({tag, ".b.fb_finished"}, 64'(fin_b), 64'(e.fin));
    checkOutput({tag, ".b.fb_replay"}, 64'(rep_b), 64'(e.rep));
    checkOutput({tag, ".b.fb_idx"}, 64'(fidx_b), 64'(e.idx));
    advanceModel(1, g, rr_b, cnt_b, held_b, e);
    sb_b.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset, directed table, hand-written corner rows, random traffic.
  initial begin
    //          rst   stall  vld    need    grant  rd_vld   (6-port instance)
    tbl[0]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 4'h7, 6'h3F};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 8'hFF, 4'h0, 6'h00};
    tbl[2]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 4'hE, 6'h3F};
    tbl[3]  = '{1'b0, 1'b0, 4'h1, 8'hFF, 4'h1, 6'h03};
    tbl[4]  = '{1'b0, 1'b0, 4'h8, 8'hFF, 4'h8, 6'h03};
    tbl[5]  = '{1'b0, 1'b0, 4'hF, 8'hDF, 4'h7, 6'h1F};
    tbl[6]  = '{1'b0, 1'b0, 4'hF, 8'hBD, 4'hF, 6'h3F};
    tbl[7]  = '{1'b0, 1'b0, 4'hF, 8'hF3, 4'hF, 6'h3F};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 8'hFF, 4'hB, 6'h3F};
    tbl[9]  = '{1'b0, 1'b1, 4'hF, 8'hFF, 4'h0, 6'h00};
    tbl[10] = '{1'b0, 1'b0, 4'hF, 8'hFF, 4'h7, 6'h3F};
    tbl[11] = '{1'b1, 1'b0, 4'hF, 8'hFF, 4'h0, 6'h00};
    tbl[12] = '{1'b0, 1'b0, 4'hF, 8'hFF, 4'h7, 6'h3F};
    tbl[13] = '{1'b0, 1'b0, 4'h5, 8'h21, 4'h5, 6'h03};

    rst = 1'b1; stall = 1'b0; vld = '0; need = '0; idx = '0; sidx = '0;
    rr_a = 0; rr_b = 0; cnt_a = '0; cnt_b = '0; held_a = '0; held_b = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset.a.fb_finished", 64'(fin_a), 64'h0);
    checkOutput("reset.a.fb_replay", 64'(rep_a), 64'h0);
    checkOutput("reset.a.fb_idx", 64'(fidx_a), 64'h0);
    checkOutput("reset.b.fb_finished", 64'(fin_b), 64'h0);
    checkOutput("reset.b.fb_replay", 64'(rep_b), 64'h0);
    @(posedge clk);
    #1;
    sb_a.push_back('0);
    sb_b.push_back('0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].nd);
      runCycle($sformatf("row%0d", i), 1'b1, tbl[i].eg, tbl[i].erv, 1'b0, 4'h0);
    end

    // Starvation override on the 3-port build: r2 is denied, then jumps ahead of rr order.
    applyStimulus(1'b1, 1'b0, 4'hF, 8'hFF);
    runCycle("starve.reset", 1'b1, 4'h0, 6'h00, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h7, 8'h3D);
    runCycle("starve.deny", 1'b1, 4'h7, 6'h1F, 1'b1, 4'h3);
    applyStimulus(1'b0, 1'b0, 4'hF, 8'hFF);
    runCycle("starve.force", 1'b1, 4'hE, 6'h3F, 1'b1, 4'h4);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0,
                    4'($urandom()), 8'($urandom()));
      runCycle($sformatf("rand%0d", i), 1'b0, 4'h0, 6'h00, 1'b0, 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
